// File: rtl/aes_round_ctrl.sv
// ---------------------------------------------------------------------------
// aes_round_ctrl
//   Sequencer for the iterative AES-128 encryption core.
//   - Owns the 128-bit state register.
//   - Accepts one plaintext block on a valid/ready handshake.
//   - Runs the external round datapath once per cycle.
//   - Presents the round-key index to the key store.
//   - Flags the final round so the datapath can skip MixColumns.
//
//   Optional feature macro: AES_CTRL_ABORT_EN
//     When defined, an extra 'abort' input cancels the block in flight.
//
// Ports
//   clk        in   1        rising-edge clock
//   rst_n      in   1        asynchronous active-low reset
//   abort      in   1        (AES_CTRL_ABORT_EN only) drop current block
//   in_valid   in   1        plaintext valid
//   in_ready   out  1        controller idle, can take a block
//   in_data    in   128      plaintext, byte 0 in [127:120], column-major
//   rk_idx     out  RK_IDX_W round-key index to the key store
//   round_key  in   128      round key for rk_idx (same cycle)
//   dp_state   out  128      state register, feeds the round datapath
//   dp_last    out  1        final round: datapath bypasses MixColumns
//   dp_result  in   128      datapath output
//   out_valid  out  1        ciphertext valid
//   out_ready  in   1        downstream accepts ciphertext
//   out_data   out  128      ciphertext (state register)
//   busy       out  1        controller not idle
//
// State table
//   state   | meaning
//   S_IDLE  | waiting for a plaintext block; in_ready = 1
//   S_ROUND | one datapath round per cycle, rk_idx = round counter
//   S_DONE  | ciphertext held on out_data until out_ready
// ---------------------------------------------------------------------------
module aes_round_ctrl #(
  parameter int NUM_ROUNDS = 10,
  parameter int RK_IDX_W   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
`ifdef AES_CTRL_ABORT_EN
  input  logic                abort,
`endif
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        in_data,
  output logic [RK_IDX_W-1:0] rk_idx,
  input  logic [127:0]        round_key,
  output logic [127:0]        dp_state,
  output logic                dp_last,
  input  logic [127:0]        dp_result,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        out_data,
  output logic                busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ROUND = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [RK_IDX_W-1:0] LAST_RND = RK_IDX_W'(NUM_ROUNDS);
  localparam logic [RK_IDX_W-1:0] FIRST_RND = RK_IDX_W'(1);

  logic [1:0]          r_fsm;
  logic [RK_IDX_W-1:0] r_round;
  logic [127:0]        r_state;

  logic w_abort;
  logic w_final;

`ifdef AES_CTRL_ABORT_EN
  // Abort only matters once a block has been taken; in IDLE it is a no-op.
  assign w_abort = abort && (r_fsm != S_IDLE);
`else
  assign w_abort = 1'b0;
`endif

  assign w_final = (r_round == LAST_RND);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm   <= S_IDLE;
      r_round <= '0;
      r_state <= '0;
    end else if (w_abort) begin
      r_fsm   <= S_IDLE;
      r_round <= '0;
      r_state <= '0;
    end else begin
      case (r_fsm)
        S_IDLE: begin
          // in_ready is 1 in IDLE, so in_valid alone completes the handshake.
          // rk_idx is 0 here, so round_key is the whitening key.
          if (in_valid) begin
            r_state <= in_data ^ round_key;
            r_round <= FIRST_RND;
            r_fsm   <= S_ROUND;
          end
        end
        S_ROUND: begin
          r_state <= dp_result;
          if (w_final) begin
            r_fsm <= S_DONE;
          end else begin
            r_round <= r_round + FIRST_RND;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_fsm   <= S_IDLE;
            r_round <= '0;
          end
        end
        default: begin
          r_fsm   <= S_IDLE;
          r_round <= '0;
        end
      endcase
    end
  end

  // The round counter is 0 whenever the FSM is idle, so it can drive
  // rk_idx directly in every state.
  assign rk_idx    = r_round;
  assign dp_state  = r_state;
  assign out_data  = r_state;
  assign dp_last   = (r_fsm == S_ROUND) && w_final;
  assign in_ready  = (r_fsm == S_IDLE);
  assign out_valid = (r_fsm == S_DONE);
  assign busy      = (r_fsm != S_IDLE);

endmodule

// File: tb/tb_aes_round_ctrl.sv
// ---------------------------------------------------------------------------
// tb_aes_round_ctrl
//   Drives aes_round_ctrl with a behavioural AES round datapath and key store.
//   Expected ciphertexts are queued at issue time and checked by a monitor.
// ---------------------------------------------------------------------------
module tb_aes_round_ctrl;
  localparam int NR = 10;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic [3:0]   rk_idx;
  logic [127:0] round_key;
  logic [127:0] dp_state;
  logic         dp_last;
  logic [127:0] dp_result;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;
  logic         busy;
`ifdef AES_CTRL_ABORT_EN
  logic         abort = 1'b0;
`endif

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int acc_cyc = -1000;
  bit tracking = 0;
  bit prev_ov  = 0;
  bit rand_or  = 0;

  logic [7:0]   sbox [256];
  logic [127:0] rk_tab [11];
  logic [127:0] exp_q [$];

  aes_round_ctrl #(.NUM_ROUNDS(NR), .RK_IDX_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef AES_CTRL_ABORT_EN
    .abort(abort),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .rk_idx(rk_idx), .round_key(round_key),
    .dp_state(dp_state), .dp_last(dp_last), .dp_result(dp_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- AES reference model ----------------
  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                    ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word(logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  function automatic logic [127:0] exp_key(logic [127:0] key, int r);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] aes_round(logic [127:0] s, logic [127:0] k, logic last);
    logic [7:0] a [16];
    logic [7:0] b [16];
    logic [7:0] t0, t1, t2, t3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) a[i] = sbox[s[127-8*i -: 8]];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) b[r+4*c] = a[r+4*((c+r)%4)];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        t0 = b[4*c]; t1 = b[4*c+1]; t2 = b[4*c+2]; t3 = b[4*c+3];
        b[4*c]   = gmul(t0, 8'h02) ^ gmul(t1, 8'h03) ^ t2 ^ t3;
        b[4*c+1] = t0 ^ gmul(t1, 8'h02) ^ gmul(t2, 8'h03) ^ t3;
        b[4*c+2] = t0 ^ t1 ^ gmul(t2, 8'h02) ^ gmul(t3, 8'h03);
        b[4*c+3] = gmul(t0, 8'h03) ^ t1 ^ t2 ^ gmul(t3, 8'h02);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = b[i];
    return o ^ k;
  endfunction

  function automatic logic [127:0] aes_ref(logic [127:0] pt, logic [127:0] key);
    logic [127:0] s = pt ^ exp_key(key, 0);
    for (int r = 1; r <= NR; r++) s = aes_round(s, exp_key(key, r), r == NR);
    return s;
  endfunction

  // Behavioural key store and round datapath seen by the DUT.
  always_comb begin
    round_key = (rk_idx <= 4'(NR)) ? rk_tab[rk_idx] : '0;
    dp_result = aes_round(dp_state, round_key, dp_last);
  end

  // ---------------- checking ----------------
  task automatic check(string name, logic [127:0] act, logic [127:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, expv);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) begin
        check("accept_rk_idx", rk_idx, 0);
        acc_cyc  = cyc;
        tracking = 1;
      end else if (tracking && (cyc - acc_cyc) >= 1 && (cyc - acc_cyc) <= NR) begin
        check("rk_idx_seq", rk_idx, cyc - acc_cyc);
        check("dp_last", dp_last, (cyc - acc_cyc) == NR);
        check("busy_round", busy, 1);
        check("in_ready_round", in_ready, 0);
      end
      if (out_valid && !prev_ov) check("latency", cyc - acc_cyc, NR + 1);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_out", out_valid, 0);
        else check("out_data", out_data, exp_q.pop_front());
        tracking = 0;
      end
      prev_ov = out_valid;
    end else begin
      prev_ov = 0;
    end
  end

  always @(posedge clk) if (rand_or) #1 out_ready = 1'($urandom_range(0, 1));

  // ---------------- stimulus ----------------
  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic set_key(logic [127:0] k);
    for (int r = 0; r <= NR; r++) rk_tab[r] = exp_key(k, r);
  endtask

  task automatic send(logic [127:0] pt, logic [127:0] expct);
    exp_q.push_back(expct);
    @(posedge clk); #1;
    in_data  = pt;
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
    end
    check("accept_timeout", in_ready, 1);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && in_ready) return;
    end
    check("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_dp_last"}, dp_last, 0);
    check({tag, "_rk_idx"}, rk_idx, 0);
    check({tag, "_dp_state"}, dp_state, 0);
  endtask

  initial begin
    logic [127:0] k, p1, p2, ex;
    int t1, t2;
    build_sbox();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst_n = 1'b1;

    // FIPS-197 Appendix B vector
    k = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    set_key(k);
    out_ready = 1'b1;
    send(128'h3243f6a8885a308d313198a2e0370734, 128'h3925841d02dc09fbdc118597196a0b32);
    wait_drain();

    // Backpressure: ciphertext held, in_valid pulses ignored
    k = rnd128(); set_key(k);
    out_ready = 1'b0;
    p1 = rnd128(); ex = aes_ref(p1, k);
    send(p1, ex);
    for (int i = 0; i < 50 && !out_valid; i++) @(negedge clk);
    check("bp_out_valid", out_valid, 1);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      in_valid = 1'($urandom_range(0, 1));
      in_data  = rnd128();
      @(negedge clk);
      check("bp_out_data", out_data, ex);
      check("bp_in_ready", in_ready, 0);
      check("bp_busy", busy, 1);
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_drain();

    // Back-to-back: in_valid and out_ready held high
    k = rnd128(); set_key(k);
    p1 = rnd128(); p2 = rnd128();
    exp_q.push_back(aes_ref(p1, k));
    exp_q.push_back(aes_ref(p2, k));
    t1 = -1; t2 = -1;
    @(posedge clk); #1;
    in_data = p1; in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin t1 = cyc; @(posedge clk); #1; in_data = p2; break; end
    end
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin t2 = cyc; @(posedge clk); #1; break; end
    end
    in_valid = 1'b0;
    check("b2b_spacing", t2 - t1, NR + 2);
    wait_drain();

    // Asynchronous reset in round 5, then a fresh block
    k = rnd128(); set_key(k);
    p1 = rnd128();
    send(p1, aes_ref(p1, k));
    repeat (4) @(posedge clk);
    #2;
    check("pre_rst_rk_idx", rk_idx, 5);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    exp_q.delete();
    tracking = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    p1 = rnd128();
    send(p1, aes_ref(p1, k));
    wait_drain();

`ifdef AES_CTRL_ABORT_EN
    // Abort in round 3: back to IDLE, no output, next block fine
    p1 = rnd128();
    send(p1, aes_ref(p1, k));
    repeat (2) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_in_ready", in_ready, 1);
    check("abort_dp_state", dp_state, 0);
    exp_q.delete();
    tracking = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      check("abort_no_out", out_valid, 0);
    end
    p1 = rnd128();
    send(p1, aes_ref(p1, k));
    wait_drain();
`endif

    // Random blocks with random downstream backpressure
    rand_or = 1;
    for (int n = 0; n < 8; n++) begin
      k = rnd128(); set_key(k);
      p1 = rnd128();
      send(p1, aes_ref(p1, k));
      wait_drain();
    end
    rand_or = 0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
